mcs4_ram_master: RTL and testbench



---
 rtl/mcs4_ram_master.sv | 134 +++++++++++++
 tb/tb_mcs4_ram_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_ram_master.sv
// MCS-4 RAM bus initiator: turns host requests into SRC + I/O-RAM instruction cycles.
// Optional MCS4_SRC_CACHE_EN skips the SRC cycle when the address matches the last one sent.
module mcs4_ram_master #(
  parameter logic [2:0] SRC_PAIR = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_opa,
  input  logic [7:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       sync,
  output logic       cm_ram,
  output logic [3:0] dbus_out,
  input  logic [3:0] dbus_in
);

  typedef enum logic [1:0] {IDLE, PEND, SRC, IO} state_t;

  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  state_t     state_reg, state_next, issue_state;
  logic [2:0] cyc_reg, cyc_next;
  logic [7:0] addr_reg, addr_next;
  logic [3:0] opa_reg, opa_next;
  logic [3:0] wdata_reg, wdata_next;
  logic       accept, at_x3;
  logic       sync_next, cm_next;
  logic [3:0] dbus_next;

  function automatic logic is_read(input logic [3:0] opa);
    return (opa == 4'h8) || (opa == 4'h9) || (opa >= 4'hB);
  endfunction

`ifdef MCS4_SRC_CACHE_EN
  logic       cache_valid_reg;
  logic [7:0] cache_addr_reg;
  assign issue_state = (cache_valid_reg && (addr_next == cache_addr_reg)) ? IO : SRC;
`else
  assign issue_state = SRC;
`endif

  assign at_x3     = (cyc_reg == PH_X3);
  assign req_ready = rst_n && ((state_reg == IDLE) || ((state_reg == IO) && at_x3));
  assign accept    = req_valid && req_ready;
  assign cyc_next  = cyc_reg + 3'd1;

  always_comb begin
    addr_next  = accept ? req_addr  : addr_reg;
    opa_next   = accept ? req_opa   : opa_reg;
    wdata_next = accept ? req_wdata : wdata_reg;

    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = at_x3 ? issue_state : PEND;
      PEND:    if (at_x3) state_next = issue_state;
      SRC:     if (at_x3) state_next = IO;
      IO:      if (at_x3) state_next = accept ? issue_state : IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded one phase ahead so the registered value lines up with cyc.
    sync_next = (cyc_next == PH_X3);
    cm_next   = 1'b0;
    dbus_next = 4'h0;
    if (state_next == SRC) begin
      unique case (cyc_next)
        PH_M1: dbus_next = 4'h2;
        PH_M2: dbus_next = {SRC_PAIR, 1'b1};
        PH_X2: begin
          dbus_next = addr_next[7:4];
          cm_next   = 1'b1;
        end
        PH_X3: dbus_next = addr_next[3:0];
        default: dbus_next = 4'h0;
      endcase
    end else if (state_next == IO) begin
      unique case (cyc_next)
        PH_M1: dbus_next = 4'hE;
        PH_M2: begin
          dbus_next = opa_next;
          cm_next   = 1'b1;
        end
        PH_X2: dbus_next = is_read(opa_next) ? 4'h0 : wdata_next;
        default: dbus_next = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cyc_reg   <= 3'd6;
      addr_reg  <= 8'h00;
      opa_reg   <= 4'h0;
      wdata_reg <= 4'h0;
      sync      <= 1'b0;
      cm_ram    <= 1'b0;
      dbus_out  <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 4'h0;
`ifdef MCS4_SRC_CACHE_EN
      cache_valid_reg <= 1'b0;
      cache_addr_reg  <= 8'h00;
`endif
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      addr_reg  <= addr_next;
      opa_reg   <= opa_next;
      wdata_reg <= wdata_next;
      sync      <= sync_next;
      cm_ram    <= cm_next;
      dbus_out  <= dbus_next;
      rsp_valid <= (state_reg == IO) && (cyc_reg == PH_X2) && is_read(opa_reg);
      if ((state_reg == IO) && (cyc_reg == PH_X2) && is_read(opa_reg)) begin
        rsp_data <= dbus_in;
      end
`ifdef MCS4_SRC_CACHE_EN
      if (at_x3 && (state_next == SRC)) begin
        cache_valid_reg <= 1'b1;
        cache_addr_reg  <= addr_next;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mcs4_ram_master.sv
// Directed bench for mcs4_ram_master with a behavioural four-chip RAM model on the bus.
module tb_mcs4_ram_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_opa = 4'h0;
  logic [7:0] req_addr = 8'h00;
  logic [3:0] req_wdata = 4'h0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       sync;
  logic       cm_ram;
  logic [3:0] dbus_out;
  logic [3:0] dbus_in;

  mcs4_ram_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sync(sync), .cm_ram(cm_ram), .dbus_out(dbus_out), .dbus_in(dbus_in)
  );

  always #5 clk = ~clk;

`ifdef MCS4_SRC_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // RAM chip model: phase tracked from sync, SRC selects chip/reg/char, I/O X2 moves data.
  logic [3:0] main_mem [4][4][16];
  logic [3:0] stat_mem [4][4][4];
  logic [2:0] ph;
  logic [3:0] m1, op;
  logic [1:0] sel_chip, sel_reg;
  logic [3:0] sel_char;
  bit         io, got_x2;
  int         src_seen = 0;

  initial begin
    foreach (main_mem[a, b, c]) main_mem[a][b][c] = 4'h0;
    foreach (stat_mem[a, b, c]) stat_mem[a][b][c] = 4'h0;
    sel_chip = 0; sel_reg = 0; sel_char = 0; m1 = 0; op = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 3'd0; io = 0; got_x2 = 0; dbus_in = 4'h0;
    end else begin
      ph = sync ? 3'd7 : ph + 3'd1;
      dbus_in = 4'h0;
      case (ph)
        3'd0: io = 0;
        3'd3: m1 = dbus_out;
        3'd4: if (cm_ram && m1 == 4'hE) begin io = 1; op = dbus_out; end
        3'd6: begin
          if (cm_ram) begin
            sel_chip = dbus_out[3:2]; sel_reg = dbus_out[1:0]; got_x2 = 1; src_seen++;
          end else if (io) begin
            if (op == 4'h0) main_mem[sel_chip][sel_reg][sel_char] = dbus_out;
            else if (op >= 4'h4 && op <= 4'h7) stat_mem[sel_chip][sel_reg][op[1:0]] = dbus_out;
            else if (op == 4'h8 || op == 4'h9 || op == 4'hB) dbus_in = main_mem[sel_chip][sel_reg][sel_char];
            else if (op >= 4'hC) dbus_in = stat_mem[sel_chip][sel_reg][op[1:0]];
          end
        end
        3'd7: if (got_x2) begin sel_char = dbus_out; got_x2 = 0; end
        default: ;
      endcase
    end
  end

  logic [3:0] bus_d  [1:28];
  logic       bus_cm [1:28];

  // Offer one request in phase c; record bus activity for 28 clocks after the accept.
  task automatic do_txn(input logic [3:0] opa, input logic [7:0] addr, input logic [3:0] wdata,
                        input logic [2:0] c, output int lat, output int npulse,
                        output logic [3:0] data, output int srcs);
    bit found = 0;
    int s0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (ph == c && req_ready) found = 1;
    end
    check("wait_ready", 32'(found), 32'd1);
    req_opa = opa; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    s0 = src_seen;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; npulse = 0; data = 4'h0;
    for (int k = 1; k <= 28; k++) begin
      step();
      bus_d[k] = dbus_out;
      bus_cm[k] = cm_ram;
      if (rsp_valid) begin
        npulse++;
        if (lat == 0) begin lat = k; data = rsp_data; end
      end
    end
    srcs = src_seen - s0;
  endtask

  typedef struct {
    logic [3:0] opa;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [2:0] c;
    bit         rd;
    logic [3:0] exp;
    bit         hit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, npulse, srcs, off, io_base, n, viol, pulses;
    int acc_t [4];
    bit hit_eff, acc, found;
    logic [3:0] data;

    vecs[0]  = '{4'h0, 8'h15, 4'hA, 3'd7, 1'b0, 4'h0, 1'b0};  // WRM
    vecs[1]  = '{4'h9, 8'h15, 4'h0, 3'd7, 1'b1, 4'hA, 1'b1};  // RDM
    vecs[2]  = '{4'h6, 8'h20, 4'h3, 3'd7, 1'b0, 4'h0, 1'b0};  // WR2 chip0 reg2
    vecs[3]  = '{4'h6, 8'hE0, 4'h7, 3'd3, 1'b0, 4'h0, 1'b0};  // WR2 chip3 reg2, via PEND
    vecs[4]  = '{4'hE, 8'hE0, 4'h0, 3'd7, 1'b1, 4'h7, 1'b1};  // RD2 chip3
    vecs[5]  = '{4'hE, 8'h20, 4'h0, 3'd0, 1'b1, 4'h3, 1'b0};  // RD2 chip0, via PEND
    vecs[6]  = '{4'h0, 8'h2F, 4'h5, 3'd5, 1'b0, 4'h0, 1'b0};  // WRM
    vecs[7]  = '{4'h9, 8'h2F, 4'h0, 3'd7, 1'b1, 4'h5, 1'b1};  // RDM
    vecs[8]  = '{4'hB, 8'h15, 4'h0, 3'd7, 1'b1, 4'hA, 1'b0};  // ADM
    vecs[9]  = '{4'hA, 8'h15, 4'h9, 3'd7, 1'b0, 4'h0, 1'b1};  // RDR is write-class
    vecs[10] = '{4'h8, 8'h15, 4'h0, 3'd7, 1'b1, 4'hA, 1'b1};  // SBM
    vecs[11] = '{4'hC, 8'hE0, 4'h0, 3'd7, 1'b1, 4'h0, 1'b0};  // RD0

    repeat (3) step();
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_cm_ram", 32'(cm_ram), 32'd0);
    check("rst_dbus", 32'(dbus_out), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check($sformatf("sync_k%0d", k), 32'(sync), 32'(((k - 1) % 8) == 0));
      check($sformatf("idle_bus_k%0d", k), {27'd0, cm_ram, dbus_out}, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].opa, vecs[i].addr, vecs[i].wdata, vecs[i].c, lat, npulse, data, srcs);
      hit_eff = CACHE && vecs[i].hit;
      off = 7 - int'(vecs[i].c);
      io_base = hit_eff ? 0 : 8;
      check($sformatf("v%0d_srcs", i), 32'(srcs), hit_eff ? 32'd0 : 32'd1);
      if (hit_eff) begin
        check($sformatf("v%0d_x2_cm", i), 32'(bus_cm[off + 7]), 32'd0);
      end else begin
        check($sformatf("v%0d_src_x2_cm", i), 32'(bus_cm[off + 7]), 32'd1);
        check($sformatf("v%0d_src_x2_d", i), 32'(bus_d[off + 7]), 32'(vecs[i].addr[7:4]));
        check($sformatf("v%0d_src_x3_d", i), 32'(bus_d[off + 8]), 32'(vecs[i].addr[3:0]));
      end
      check($sformatf("v%0d_io_m2_d", i), 32'(bus_d[off + io_base + 5]), 32'(vecs[i].opa));
      check($sformatf("v%0d_io_m2_cm", i), 32'(bus_cm[off + io_base + 5]), 32'd1);
      check($sformatf("v%0d_io_x2_d", i), 32'(bus_d[off + io_base + 7]),
            vecs[i].rd ? 32'd0 : 32'(vecs[i].wdata));
      check($sformatf("v%0d_io_x2_cm", i), 32'(bus_cm[off + io_base + 7]), 32'd0);
      if (vecs[i].rd) begin
        check($sformatf("v%0d_lat", i), 32'(lat), 32'(off + io_base + 8));
        check($sformatf("v%0d_pulses", i), 32'(npulse), 32'd1);
        check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp));
      end else begin
        check($sformatf("v%0d_no_rsp", i), 32'(npulse), 32'd0);
      end
      if (i == 0) begin
        check("wrm_src_m1", 32'(bus_d[4]), 32'h2);
        check("wrm_src_m2", 32'(bus_d[5]), 32'h1);
        check("wrm_src_m2_cm", 32'(bus_cm[5]), 32'd0);
        check("wrm_io_m1", 32'(bus_d[12]), 32'hE);
        check("wrm_idle_a1", 32'(bus_d[9]), 32'h0);
      end
      if (i == 2) check("rsp_data_held", 32'(rsp_data), 32'hA);
      $display("txn %0d opa=%0h addr=%0h lat=%0d pulses=%0d data=%0h srcs=%0d",
               i, vecs[i].opa, vecs[i].addr, lat, npulse, data, srcs);
    end

    // Back-to-back: req_valid held for three WR1 writes.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (ph == 3'd7 && req_ready) found = 1;
    end
    check("b2b_start", 32'(found), 32'd1);
    req_opa = 4'h5; req_addr = 8'h40; req_wdata = 4'h1; req_valid = 1'b1;
    n = 0; viol = 0;
    for (int i = 0; i < 60; i++) begin
      acc = 0;
      if (req_valid && req_ready) begin
        if (n > 0 && ph != 3'd7) viol++;
        acc_t[n] = i; n++; acc = 1;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (n == 3) req_valid = 1'b0;
        else begin req_addr = 8'h40 + 8'(n * 16); req_wdata = 4'(n + 1); end
      end
      step();
    end
    check("b2b_accepts", 32'(n), 32'd3);
    check("b2b_gap01", 32'(acc_t[1] - acc_t[0]), 32'd16);
    check("b2b_gap12", 32'(acc_t[2] - acc_t[1]), 32'd16);
    check("b2b_ready_busy", 32'(viol), 32'd0);
    $display("txn b2b accepts=%0d t=%0d,%0d,%0d", n, acc_t[0], acc_t[1], acc_t[2]);
    do_txn(4'hD, 8'h40, 4'h0, 3'd7, lat, npulse, data, srcs);
    check("b2b_rd_40", 32'(data), 32'h1);
    $display("txn rd1 addr=40 data=%0h", data);
    do_txn(4'hD, 8'h60, 4'h0, 3'd7, lat, npulse, data, srcs);
    check("b2b_rd_60", 32'(data), 32'h3);
    $display("txn rd1 addr=60 data=%0h", data);

    // Reset during the I/O M2 phase of an RDM.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (ph == 3'd7 && req_ready) found = 1;
    end
    req_opa = 4'h9; req_addr = 8'h15; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 13; k++) step();
    check("pre_reset_cm", 32'(cm_ram), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_cm", 32'(cm_ram), 32'd0);
    check("mid_reset_dbus", 32'(dbus_out), 32'd0);
    check("mid_reset_ready", 32'(req_ready), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rsp_valid) pulses++;
    end
    check("dropped_no_rsp", 32'(pulses), 32'd0);
    $display("txn reset_mid_rdm pulses=%0d", pulses);

    do_txn(4'h9, 8'h15, 4'h0, 3'd7, lat, npulse, data, srcs);
    check("post_rst_15_srcs", 32'(srcs), 32'd1);
    check("post_rst_15_lat", 32'(lat), 32'd16);
    check("post_rst_15_data", 32'(data), 32'hA);
    $display("txn rdm addr=15 lat=%0d data=%0h srcs=%0d", lat, data, srcs);
    do_txn(4'h9, 8'h16, 4'h0, 3'd7, lat, npulse, data, srcs);
    check("rd_16_srcs", 32'(srcs), 32'd1);
    check("rd_16_lat", 32'(lat), 32'd16);
    $display("txn rdm addr=16 lat=%0d data=%0h srcs=%0d", lat, data, srcs);
    do_txn(4'h9, 8'h16, 4'h0, 3'd7, lat, npulse, data, srcs);
    check("rd_16_again_srcs", 32'(srcs), CACHE ? 32'd0 : 32'd1);
    check("rd_16_again_lat", 32'(lat), CACHE ? 32'd8 : 32'd16);
    $display("txn rdm addr=16 lat=%0d data=%0h srcs=%0d", lat, data, srcs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
